// File: rtl/tt_pad_oe_seq.sv
// tt_pad_oe_seq
//    Per-pad output-enable sequencer for bidirectional pads. Every pad has its
//    own four-state FSM. The FSM inserts one SETUP cycle before the pad drives.
//    After any drive-off event it forces a turnaround of DEAD_CYCLES cycles,
//    during which the driver stays off. This keeps two drivers from fighting
//    on the pad while the bus turns around.
//
//    Optional build macro: TT_PAD_OE_KILL_SYNC_EN
//       defined   - kill goes through a 2-flop synchronizer that resets to 1.
//                   This adds 2 cycles of kill latency and holds the pads off
//                   for 2 cycles after reset.
//       undefined - kill is used as-is and must be synchronous to clk.
//
// Parameters
//    WIDTH       - number of pads
//    DEAD_CYCLES - turnaround length after drive-off; legal range 1..15
//
// Ports
//    clk     in   single clock; all state changes on its rising edge
//    rst_n   in   asynchronous active-low reset
//    oe_req  in   [WIDTH] per-pad drive request; 1 = drive
//    out_req in   [WIDTH] per-pad drive data
//    kill    in   global release; 1 = all pads go to high-Z
//    tx_en   out  [WIDTH] tristate enable; 1 = driving; registered
//    pad_out out  [WIDTH] out_req, registered with one cycle of latency
//    busy    out  1 while any pad is in SETUP or TURN; registered
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | pad released; waits for oe_req with kill inactive
// SETUP | one-cycle arm step; the driver is still off
// ON    | pad driven
// TURN  | forced-off turnaround; counts DEAD_CYCLES-1 down to 0, ignores inputs

module tt_pad_oe_seq #(
    parameter int WIDTH       = 8,
    parameter int DEAD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] oe_req,
    input  logic [WIDTH-1:0] out_req,
    input  logic             kill,
    output logic [WIDTH-1:0] tx_en,
    output logic [WIDTH-1:0] pad_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SETUP = 2'd1,
        ST_ON    = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    state_t           state     [WIDTH];
    state_t           state_nxt [WIDTH];
    logic   [3:0]     cnt       [WIDTH];
    logic   [3:0]     cnt_nxt   [WIDTH];
    logic [WIDTH-1:0] tx_en_nxt;
    logic             busy_nxt;
    logic             kill_i;

`ifdef TT_PAD_OE_KILL_SYNC_EN
    // The synchronizer resets to 1, so pads stay released until it has
    // flushed after reset.
    logic [1:0] kill_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_sync <= 2'b11;
        end else begin
            kill_sync <= {kill_sync[0], kill};
        end
    end

    assign kill_i = kill_sync[1];
`else
    assign kill_i = kill;
`endif

    always_comb begin
        busy_nxt  = 1'b0;
        tx_en_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_OFF: begin
                    if (oe_req[i] && !kill_i) state_nxt[i] = ST_SETUP;
                end
                ST_SETUP: begin
                    state_nxt[i] = (oe_req[i] && !kill_i) ? ST_ON : ST_OFF;
                end
                ST_ON: begin
                    if (!oe_req[i] || kill_i) begin
                        state_nxt[i] = ST_TURN;
                        cnt_nxt[i]   = DEAD_LOAD;
                    end
                end
                default: begin
                    if (cnt[i] == 4'd0) begin
                        state_nxt[i] = ST_OFF;
                    end else begin
                        cnt_nxt[i] = cnt[i] - 4'd1;
                    end
                end
            endcase
            // Outputs are decoded from the next state and then registered.
            // This keeps them cycle-aligned with the state and free of any
            // combinational path from the inputs.
            tx_en_nxt[i] = (state_nxt[i] == ST_ON);
            if (state_nxt[i] == ST_SETUP || state_nxt[i] == ST_TURN) busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_OFF;
                cnt[i]   <= 4'd0;
            end
            tx_en   <= '0;
            pad_out <= '0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            tx_en   <= tx_en_nxt;
            pad_out <= out_req;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_tt_pad_oe_seq.sv
// Testbench for tt_pad_oe_seq (WIDTH=8, DEAD_CYCLES=3).
module tb_tt_pad_oe_seq;

    localparam int W  = 8;
    localparam int DC = 3;

    localparam int M_OFF   = 0;
    localparam int M_SETUP = 1;
    localparam int M_ON    = 2;
    localparam int M_TURN  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] oe_req = '0;
    logic [W-1:0] out_req = '0;
    logic         kill = 1'b0;
    logic [W-1:0] tx_en;
    logic [W-1:0] pad_out;
    logic         busy;

    tt_pad_oe_seq #(.WIDTH(W), .DEAD_CYCLES(DC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .oe_req  (oe_req),
        .out_req (out_req),
        .kill    (kill),
        .tx_en   (tx_en),
        .pad_out (pad_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] tx;
        logic         bsy;
        logic [W-1:0] po;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int   m_mode [W];
    int   m_left [W];
    logic [1:0] m_ks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_mode[i] = M_OFF;
            m_left[i] = 0;
        end
        m_ks = 2'b11;
        sb_q.delete();
    endtask

    // One clock cycle: predict the post-edge outputs, push them, clock the
    // DUT, then pop the prediction and compare it against the DUT.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        logic ki;
`ifdef TT_PAD_OE_KILL_SYNC_EN
        ki   = m_ks[1];
        m_ks = {m_ks[0], kill};
`else
        ki = kill;
`endif
        e.bsy = 1'b0;
        for (int i = 0; i < W; i++) begin
            case (m_mode[i])
                M_OFF:   if (oe_req[i] && !ki) m_mode[i] = M_SETUP;
                M_SETUP: m_mode[i] = (oe_req[i] && !ki) ? M_ON : M_OFF;
                M_ON: if (!oe_req[i] || ki) begin
                    m_mode[i] = M_TURN;
                    m_left[i] = DC;
                end
                default: begin
                    if (m_left[i] == 1) m_mode[i] = M_OFF;
                    m_left[i]--;
                end
            endcase
            e.tx[i] = (m_mode[i] == M_ON);
            if (m_mode[i] == M_SETUP || m_mode[i] == M_TURN) e.bsy = 1'b1;
        end
        e.po = out_req;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_tx"},   32'(tx_en),   32'(got.tx));
            chk({tag, "_busy"}, 32'(busy),    32'(got.bsy));
            chk({tag, "_pout"}, 32'(pad_out), 32'(got.po));
        end
    endtask

    task automatic settle_off();
        oe_req = '0;
        kill   = 1'b0;
        for (int k = 0; k < DC + 3; k++) step("settle");
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_tx",   32'(tx_en),   32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_pout", 32'(pad_out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef TT_PAD_OE_KILL_SYNC_EN
        // Pads held off after reset while the synchronizer flushes.
        oe_req  = 8'hFF;
        out_req = 8'h3C;
        chk("ks_rel_c0", 32'(tx_en), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step("ks_rel");
            chk($sformatf("ks_rel_c%0d", k), 32'(tx_en), 32'd0);
        end
        for (int k = 0; k < 3; k++) step("ks_on");
        chk("ks_all_on", 32'(tx_en), 32'hFF);
        kill = 1'b1;
        step("ks_kill_c1");
        kill = 1'b0;
        chk("ks_kill_c1_tx", 32'(tx_en), 32'hFF);
        step("ks_kill_c2");
        chk("ks_kill_c2_tx", 32'(tx_en), 32'hFF);
        step("ks_kill_c3");
        chk("ks_kill_c3_tx", 32'(tx_en), 32'h00);
        settle_off();
`else
        // Drive-on latency: SETUP at cycle 1, ON at cycle 2.
        oe_req  = 8'h01;
        out_req = 8'hA5;
        chk("don_c0_tx", 32'(tx_en[0]), 32'd0);
        step("don_c1");
        chk("don_c1_tx",   32'(tx_en[0]), 32'd0);
        chk("don_c1_busy", 32'(busy),     32'd1);
        out_req = 8'h5A;
        step("don_c2");
        chk("don_c2_tx",   32'(tx_en[0]), 32'd1);
        chk("don_c2_busy", 32'(busy),     32'd0);

        // Dead time: off at cycle 0, re-request at cycle 1, back on at cycle 6.
        oe_req = 8'h00;
        step("dt_c1");
        chk("dt_c1_tx", 32'(tx_en[0]), 32'd0);
        oe_req = 8'h01;
        for (int k = 2; k <= 6; k++) begin
            step("dt");
            chk($sformatf("dt_c%0d_tx", k), 32'(tx_en[0]), (k == 6) ? 32'd1 : 32'd0);
        end

        // Kill with every pad driving.
        oe_req = 8'hFF;
        step("kl_up1");
        step("kl_up2");
        chk("kl_all_on", 32'(tx_en), 32'hFF);
        kill = 1'b1;
        step("kl_c1");
        kill = 1'b0;
        chk("kl_c1_tx",   32'(tx_en), 32'h00);
        chk("kl_c1_busy", 32'(busy),  32'd1);
        step("kl_c2");
        chk("kl_c2_busy", 32'(busy), 32'd1);
        step("kl_c3");
        chk("kl_c3_busy", 32'(busy), 32'd1);
        step("kl_c4");
        chk("kl_c4_busy", 32'(busy), 32'd0);
        settle_off();

        // Kill on the same cycle as the request rises.
        kill   = 1'b1;
        oe_req = 8'hFF;
        step("sim_c1");
        chk("sim_c1_tx",   32'(tx_en), 32'h00);
        chk("sim_c1_busy", 32'(busy),  32'd0);
        kill = 1'b0;
        step("sim_c2");
        chk("sim_c2_tx", 32'(tx_en), 32'h00);
        step("sim_c3");
        chk("sim_c3_tx", 32'(tx_en), 32'hFF);
        settle_off();

        // Kill during SETUP sends the pads back to OFF.
        oe_req = 8'h0F;
        step("kset_setup");
        kill = 1'b1;
        step("kset_off");
        chk("kset_off_busy", 32'(busy), 32'd0);
        kill = 1'b0;
        step("kset_setup2");
        step("kset_on");
        chk("kset_on_tx", 32'(tx_en), 32'h0F);
        settle_off();
`endif

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            oe_req  = W'($urandom);
            out_req = W'($urandom);
            kill    = ($urandom_range(7) == 0);
            step("rnd");
        end
        settle_off();

        // Asynchronous reset in the middle of TURN.
        oe_req  = 8'h01;
        out_req = 8'hC3;
        for (int k = 0; k < 3; k++) step("rt_on");
        oe_req = 8'h00;
        step("rt_turn");
        chk("rt_turn_busy", 32'(busy), 32'd1);
        oe_req = 8'h01;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rt_rst_tx",   32'(tx_en),   32'd0);
        chk("rt_rst_busy", 32'(busy),    32'd0);
        chk("rt_rst_pout", 32'(pad_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
`ifndef TT_PAD_OE_KILL_SYNC_EN
        step("rt_rel1");
        chk("rt_rel1_tx", 32'(tx_en[0]), 32'd0);
        step("rt_rel2");
        chk("rt_rel2_tx", 32'(tx_en[0]), 32'd1);
`else
        for (int k = 0; k < 5; k++) step("rt_rel");
        chk("rt_rel_tx", 32'(tx_en[0]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
